sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_SPRITES, default 4, number of sprite channels (1..8).
REQ-002 Parameter SPRITE_W, default 32, sprite width in pixels.
REQ-003 Parameter SPRITE_H, default 32, sprite height in pixels.
REQ-004 Parameter COORD_W, default 10, width of each coordinate.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 frameStart  input  1  one-cycle pulse marking the start of a frame.
REQ-008 bright  input  1  visible-area flag.
REQ-009 hCount, vCount  input  COORD_W each  current pixel coordinates.
REQ-010 spritePos  input  NUM_SPRITES*2*COORD_W  per sprite {X,Y}; sprite i occupies bits [i*2*COORD_W +: 2*COORD_W]; X is the left edge, Y is the bottom edge.
REQ-011 spriteEn  input  NUM_SPRITES  per-sprite enable.
REQ-012 spriteColor  input  NUM_SPRITES*12  per-sprite RGB444 colour.
REQ-013 blockType  input  3  background tile type for the current pixel.
REQ-014 rgb  output  12  registered pixel colour.
REQ-015 overlapMask  output  NUM_SPRITES  per-sprite overlap flags for the previous frame.

Function
REQ-016 On frameStart, spritePos, spriteEn and spriteColor shall be latched into shadow registers; all pixel decisions shall use shadow values only.
REQ-017 On a frameStart cycle, the pixel decision shall use the pre-latch shadow values; new values take effect from the next cycle.
REQ-018 Sprite i shall cover a pixel when shadow enable i=1, X<=hCount<=X+SPRITE_W-1, and Y-(SPRITE_H-1)<=vCount<=Y.
REQ-019 Coverage arithmetic shall use COORD_W+1 bits with no wrap: X+SPRITE_W-1 beyond 2^COORD_W-1 extends off-screen; Y<SPRITE_H-1 clamps the top edge to 0.
REQ-020 Colour priority: bright=0 gives 12'h000; else the lowest-index covering sprite gives its shadow colour; else blockType 0 gives 12'hF00, 1 gives 12'h00F, and any other value gives 12'h0F0.
REQ-021 rgb shall have exactly one cycle of latency: rgb after edge n+1 reflects the inputs sampled at edge n.
REQ-022 Overlap accumulator: on a bright pixel covered by two or more sprites, each covering sprite's accumulator bit shall be set.
REQ-023 On frameStart, overlapMask shall load the accumulator ORed with the current cycle's contribution, and the accumulator shall clear in the same cycle.
REQ-024 overlapMask shall be held constant between frameStart pulses.
REQ-025 Back-to-back frameStart pulses shall each publish and clear the accumulator, and each shall re-latch the shadow registers.

Reset
REQ-026 While reset=1, the following shall clear to 0: rgb, overlapMask, the accumulator, and all shadow registers (all sprites disabled).
REQ-027 Reset shall take priority over frameStart in the same cycle.
REQ-028 After reset, the first rgb value shall come from background or black until the first frameStart.

Configuration
REQ-029 Macro COMPOSITOR_OVERLAP_EN: when defined, overlap detection (REQ-022..REQ-025) is compiled in.
REQ-030 When COMPOSITOR_OVERLAP_EN is undefined, overlapMask shall be constant 0, no accumulator logic shall exist, and rgb behaviour shall be identical.

Structure
REQ-031 Shared package display_pkg shall hold the colour constants (BLACK, BG_RED 12'hF00, BG_BLUE 12'h00F, GREEN 12'h0F0), the default sprite dimensions, and the blockType encodings.
REQ-032 Sub-module sprite_hit_test (combinational coverage test for one sprite per REQ-018/019) shall be instantiated NUM_SPRITES times via generate.

Verification
REQ-033 Reset, then frameStart with sprite0 at X=100, Y=200, colour 12'hDAD, enabled; pixel (100,169), bright=1 -> rgb=12'hDAD one cycle later; pixels (99,169) and (100,168) -> background colour.
REQ-034 Sprites 0 and 2 both cover (50,50) with colours 12'h111 and 12'h222 -> rgb=12'h111; disable sprite0 at the next frameStart -> rgb=12'h222.
REQ-035 Change spritePos without frameStart -> rgb unchanged; pulse frameStart on a covered pixel -> that pixel uses old values, new position takes effect next cycle.
REQ-036 Sprite at Y=10 (clamped top), X=1000 (off-screen right) -> covers rows 0..10 and columns 1000..1023 only, with no wrap to column 0.
REQ-037 With COMPOSITOR_OVERLAP_EN defined, sprites 1 and 3 overlap during frame k -> at the frame k+1 frameStart overlapMask=4'b1010; at the frame k+2 frameStart with no overlap -> 4'b0000.
REQ-038 Assert reset mid-frame with a sprite covering the pixel -> rgb=0 next cycle and sprite absent until the next frameStart.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg -- shared display constants for the sprite compositor slice.
// Holds the RGB444 colour constants, the default sprite dimensions, the
// blockType encodings, and a helper that maps a blockType to its background
// colour.
package display_pkg;

  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] BG_RED  = 12'hF00;
  localparam logic [11:0] BG_BLUE = 12'h00F;
  localparam logic [11:0] GREEN   = 12'h0F0;

  localparam int DEFAULT_SPRITE_W = 32;
  localparam int DEFAULT_SPRITE_H = 32;

  localparam logic [2:0] BLOCK_RED  = 3'd0;
  localparam logic [2:0] BLOCK_BLUE = 3'd1;

  // Every encoding other than red/blue renders as green.
  function automatic logic [11:0] backgroundColor(input logic [2:0] blockType);
    case (blockType)
      BLOCK_RED:  backgroundColor = BG_RED;
      BLOCK_BLUE: backgroundColor = BG_BLUE;
      default:    backgroundColor = GREEN;
    endcase
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if -- pixel/configuration bus of the sprite compositor.
// Signals:
//   frameStart  one-cycle frame start pulse
//   bright      visible-area flag
//   hCount      current column, vCount current row
//   spritePos   per sprite {X,Y}, sprite i at [i*2*COORD_W +: 2*COORD_W]
//   spriteEn    per-sprite enable
//   spriteColor per-sprite RGB444 colour
//   blockType   background tile type of the current pixel
//   rgb         registered pixel colour (returned)
//   overlapMask per-sprite overlap flags of the previous frame (returned)
// Modports: master drives the pixel stream, slave is the compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10
);
  logic                             frameStart;
  logic                             bright;
  logic [COORD_W-1:0]               hCount;
  logic [COORD_W-1:0]               vCount;
  logic [NUM_SPRITES*2*COORD_W-1:0] spritePos;
  logic [NUM_SPRITES-1:0]           spriteEn;
  logic [NUM_SPRITES*12-1:0]        spriteColor;
  logic [2:0]                       blockType;
  logic [11:0]                      rgb;
  logic [NUM_SPRITES-1:0]           overlapMask;

  modport master (
    output frameStart, bright, hCount, vCount, spritePos, spriteEn,
           spriteColor, blockType,
    input  rgb, overlapMask
  );

  modport slave (
    input  frameStart, bright, hCount, vCount, spritePos, spriteEn,
           spriteColor, blockType,
    output rgb, overlapMask
  );
endinterface

// File: rtl/sprite_hit_test.sv
// sprite_hit_test -- combinational coverage test for one sprite.
// Ports:
//   enable          shadow enable of the sprite
//   spriteX/Y       left edge / bottom edge of the sprite
//   hCount/vCount   pixel under test
//   hit             1 when the sprite covers the pixel
// All compares run one bit wider than the coordinates so a right edge past
// the last column stays off-screen instead of wrapping to column 0, and a
// bottom edge closer than SPRITE_H-1 to row 0 clamps the top edge at 0.
module sprite_hit_test
  import display_pkg::*;
#(
  parameter int SPRITE_W = DEFAULT_SPRITE_W,
  parameter int SPRITE_H = DEFAULT_SPRITE_H,
  parameter int COORD_W  = 10
) (
  input  logic               enable,
  input  logic [COORD_W-1:0] spriteX,
  input  logic [COORD_W-1:0] spriteY,
  input  logic [COORD_W-1:0] hCount,
  input  logic [COORD_W-1:0] vCount,
  output logic               hit
);

  localparam logic [COORD_W:0] WIDTH_M1  = (COORD_W+1)'(SPRITE_W - 1);
  localparam logic [COORD_W:0] HEIGHT_M1 = (COORD_W+1)'(SPRITE_H - 1);

  logic [COORD_W:0] xLeft, xRight, yBottom, yTop, hExt, vExt;

  assign xLeft   = {1'b0, spriteX};
  assign yBottom = {1'b0, spriteY};
  assign hExt    = {1'b0, hCount};
  assign vExt    = {1'b0, vCount};
  assign xRight  = xLeft + WIDTH_M1;
  assign yTop    = (yBottom >= HEIGHT_M1) ? (yBottom - HEIGHT_M1) : '0;

  assign hit = enable && (hExt >= xLeft) && (hExt <= xRight) &&
               (vExt >= yTop) && (vExt <= yBottom);

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor -- overlays up to NUM_SPRITES rectangular sprites on a
// tile background and produces a registered RGB444 pixel.
// Ports:
//   clk    pixel clock, all state on its rising edge
//   reset  synchronous active-high reset
//   bus    sprite_compositor_if.slave (pixel stream in, rgb/overlapMask out)
// Sprite configuration is captured into shadow registers on frameStart so a
// frame is always drawn with one consistent set of positions/colours; the
// pixel on the frameStart cycle itself still uses the previous shadow set.
// Build option: define COMPOSITOR_OVERLAP_EN to compile in overlap
// detection. Without it overlapMask is tied to 0 and no accumulator exists.
module sprite_compositor
  import display_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = DEFAULT_SPRITE_W,
  parameter int SPRITE_H    = DEFAULT_SPRITE_H,
  parameter int COORD_W     = 10
) (
  input  logic                clk,
  input  logic                reset,
  sprite_compositor_if.slave  bus
);

  localparam int POS_W = 2 * COORD_W;

  logic [NUM_SPRITES*POS_W-1:0] shPos;
  logic [NUM_SPRITES-1:0]       shEn;
  logic [NUM_SPRITES*12-1:0]    shColor;
  logic [NUM_SPRITES-1:0]       hit;
  logic [11:0]                  pixelColor;

  always_ff @(posedge clk) begin
    if (reset) begin
      shPos   <= '0;
      shEn    <= '0;
      shColor <= '0;
    end else if (bus.frameStart) begin
      shPos   <= bus.spritePos;
      shEn    <= bus.spriteEn;
      shColor <= bus.spriteColor;
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : gHit
    sprite_hit_test #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .COORD_W  (COORD_W)
    ) uHit (
      .enable  (shEn[i]),
      .spriteX (shPos[i*POS_W+COORD_W +: COORD_W]),
      .spriteY (shPos[i*POS_W +: COORD_W]),
      .hCount  (bus.hCount),
      .vCount  (bus.vCount),
      .hit     (hit[i])
    );
  end

  // Scan from the highest index down so the lowest covering sprite wins.
  always_comb begin
    pixelColor = BLACK;
    if (bus.bright) begin
      pixelColor = backgroundColor(bus.blockType);
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
        if (hit[i]) pixelColor = shColor[i*12 +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.rgb <= BLACK;
    else       bus.rgb <= pixelColor;
  end

`ifdef COMPOSITOR_OVERLAP_EN
  logic [NUM_SPRITES-1:0] overlapAcc;
  logic [NUM_SPRITES-1:0] overlapNow;

  assign overlapNow = (bus.bright && ($countones(hit) >= 2)) ? hit : '0;

  // The frameStart pixel still belongs to the ending frame, so its own
  // contribution is folded into the published mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      overlapAcc      <= '0;
      bus.overlapMask <= '0;
    end else if (bus.frameStart) begin
      bus.overlapMask <= overlapAcc | overlapNow;
      overlapAcc      <= '0;
    end else begin
      overlapAcc      <= overlapAcc | overlapNow;
    end
  end
`else
  assign bus.overlapMask = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

  localparam int NS = 4;
  localparam int CW = 10;
  localparam int SW = 32;
  localparam int SH = 32;

  logic clk = 1'b0;
  logic reset;

  sprite_compositor_if #(.NUM_SPRITES(NS), .COORD_W(CW)) bus ();

  sprite_compositor #(
    .NUM_SPRITES (NS),
    .SPRITE_W    (SW),
    .SPRITE_H    (SH),
    .COORD_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: the frame's sprite set and the overlap bookkeeping.
  int          shX [NS];
  int          shY [NS];
  bit          shEn [NS];
  logic [11:0] shCol [NS];
  logic [NS-1:0] acc;
  logic [NS-1:0] expMask;
  logic [11:0]   expRgb;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setSprite(input int i, input int x, input int y, input logic [11:0] col, input bit en);
    bus.spritePos[i*2*CW +: 2*CW] = {x[CW-1:0], y[CW-1:0]};
    bus.spriteColor[i*12 +: 12]   = col;
    bus.spriteEn[i]               = en;
  endtask

  task automatic setPixel(input int h, input int v, input bit br, input logic [2:0] bt);
    bus.hCount    = h[CW-1:0];
    bus.vCount    = v[CW-1:0];
    bus.bright    = br;
    bus.blockType = bt;
  endtask

  function automatic logic [11:0] bgOf(input logic [2:0] bt);
    if (bt == 3'd0)      return 12'hF00;
    else if (bt == 3'd1) return 12'h00F;
    else                 return 12'h0F0;
  endfunction

  // One clock: predict from the current inputs and model, advance the model,
  // then compare the registered outputs after the edge.
  task automatic cycle();
    logic [NS-1:0] cov;
    logic [NS-1:0] contrib;
    logic [11:0]   c;
    int            h, v;
    h = int'(bus.hCount);
    v = int'(bus.vCount);
    for (int i = 0; i < NS; i++)
      cov[i] = shEn[i] && (h >= shX[i]) && (h <= shX[i] + SW - 1) &&
               (v <= shY[i]) && (v >= shY[i] - (SH - 1));
    if (!bus.bright) c = 12'h000;
    else begin
      c = bgOf(bus.blockType);
      for (int i = 0; i < NS; i++) begin
        if (cov[i]) begin
          c = shCol[i];
          break;
        end
      end
    end
    contrib = (bus.bright && $countones(cov) >= 2) ? cov : '0;

    if (reset) begin
      expRgb = 12'h000;
      for (int i = 0; i < NS; i++) begin
        shX[i] = 0; shY[i] = 0; shEn[i] = 0; shCol[i] = 12'h000;
      end
      acc = '0;
      expMask = '0;
    end else begin
      expRgb = c;
      if (bus.frameStart) begin
`ifdef COMPOSITOR_OVERLAP_EN
        expMask = acc | contrib;
`endif
        acc = '0;
        for (int i = 0; i < NS; i++) begin
          shX[i]   = int'(bus.spritePos[i*2*CW+CW +: CW]);
          shY[i]   = int'(bus.spritePos[i*2*CW +: CW]);
          shEn[i]  = bus.spriteEn[i];
          shCol[i] = bus.spriteColor[i*12 +: 12];
        end
      end else begin
        acc = acc | contrib;
      end
    end

    @(posedge clk);
    #1;
    checkVal("rgb", 32'(bus.rgb), 32'(expRgb));
    checkVal("overlapMask", 32'(bus.overlapMask), 32'(expMask));
  endtask

  task automatic frameCycle();
    bus.frameStart = 1'b1;
    cycle();
    bus.frameStart = 1'b0;
  endtask

  logic [NS-1:0] maskWant;

  initial begin
    reset = 1'b1;
    bus.frameStart  = 1'b0;
    bus.spritePos   = '0;
    bus.spriteEn    = '0;
    bus.spriteColor = '0;
    setPixel(0, 0, 1'b1, 3'd0);
    acc = '0; expMask = '0; expRgb = '0;
    for (int i = 0; i < NS; i++) begin
      shX[i] = 0; shY[i] = 0; shEn[i] = 0; shCol[i] = 12'h000;
    end

    // Reset, with a frameStart that reset must override.
    setSprite(0, 0, 10, 12'h777, 1'b1);
    bus.frameStart = 1'b1;
    cycle();
    bus.frameStart = 1'b0;
    cycle();
    checkVal("reset_rgb", 32'(bus.rgb), 32'h0);
    checkVal("reset_mask", 32'(bus.overlapMask), 32'h0);
    reset = 1'b0;
    setPixel(5, 5, 1'b1, 3'd1);
    cycle();
    checkVal("post_reset_bg", 32'(bus.rgb), 32'h00F);

    // Single sprite edges.
    setSprite(0, 100, 200, 12'hDAD, 1'b1);
    frameCycle();
    setPixel(100, 169, 1'b1, 3'd0); cycle();
    checkVal("s0_corner", 32'(bus.rgb), 32'hDAD);
    setPixel(99, 169, 1'b1, 3'd0);  cycle();
    checkVal("s0_left_out", 32'(bus.rgb), 32'hF00);
    setPixel(100, 168, 1'b1, 3'd2); cycle();
    checkVal("s0_top_out", 32'(bus.rgb), 32'h0F0);
    setPixel(100, 169, 1'b0, 3'd0); cycle();
    checkVal("dark", 32'(bus.rgb), 32'h000);

    // Priority between sprites 0 and 2.
    setSprite(0, 40, 60, 12'h111, 1'b1);
    setSprite(2, 30, 70, 12'h222, 1'b1);
    frameCycle();
    setPixel(50, 50, 1'b1, 3'd0); cycle();
    checkVal("prio_low", 32'(bus.rgb), 32'h111);
    bus.spriteEn[0] = 1'b0;
    frameCycle();
    cycle();
    checkVal("prio_s2", 32'(bus.rgb), 32'h222);

    // Shadowing: live changes ignored until frameStart, which itself uses old values.
    setSprite(2, 0, 0, 12'h000, 1'b0);
    setSprite(0, 100, 200, 12'hABC, 1'b1);
    frameCycle();
    setPixel(110, 180, 1'b1, 3'd1); cycle();
    checkVal("shadow_base", 32'(bus.rgb), 32'hABC);
    setSprite(0, 500, 200, 12'hABC, 1'b1);
    cycle();
    checkVal("shadow_hold", 32'(bus.rgb), 32'hABC);
    frameCycle();
    checkVal("shadow_fs_old", 32'(bus.rgb), 32'hABC);
    cycle();
    checkVal("shadow_new", 32'(bus.rgb), 32'h00F);

    // Clamped top edge and right edge past the last column.
    setSprite(0, 1000, 10, 12'h5A5, 1'b1);
    frameCycle();
    setPixel(1000, 0, 1'b1, 3'd0);  cycle(); checkVal("clip_tl", 32'(bus.rgb), 32'h5A5);
    setPixel(1023, 10, 1'b1, 3'd0); cycle(); checkVal("clip_br", 32'(bus.rgb), 32'h5A5);
    setPixel(1010, 11, 1'b1, 3'd0); cycle(); checkVal("clip_below", 32'(bus.rgb), 32'hF00);
    setPixel(0, 5, 1'b1, 3'd0);     cycle(); checkVal("clip_nowrap", 32'(bus.rgb), 32'hF00);
    setPixel(999, 5, 1'b1, 3'd0);   cycle(); checkVal("clip_left", 32'(bus.rgb), 32'hF00);

    // Overlap of sprites 1 and 3 in one frame, none in the next.
    setSprite(0, 0, 0, 12'h000, 1'b0);
    setSprite(1, 300, 300, 12'h123, 1'b1);
    setSprite(3, 310, 310, 12'h456, 1'b1);
    frameCycle();
    setPixel(315, 295, 1'b1, 3'd0); cycle();
    setPixel(305, 270, 1'b1, 3'd0); cycle();
    frameCycle();
`ifdef COMPOSITOR_OVERLAP_EN
    maskWant = 4'b1010;
`else
    maskWant = 4'b0000;
`endif
    checkVal("ovl_frame_k", 32'(bus.overlapMask), 32'(maskWant));
    cycle(); cycle();
    frameCycle();
    checkVal("ovl_frame_k2", 32'(bus.overlapMask), 32'h0);

    // Reset mid-frame over a covered pixel.
    setSprite(1, 0, 0, 12'h000, 1'b0);
    setSprite(3, 0, 0, 12'h000, 1'b0);
    setSprite(0, 200, 200, 12'hEEE, 1'b1);
    frameCycle();
    setPixel(210, 190, 1'b1, 3'd1); cycle();
    checkVal("rst_pre", 32'(bus.rgb), 32'hEEE);
    reset = 1'b1; cycle();
    checkVal("rst_black", 32'(bus.rgb), 32'h000);
    reset = 1'b0; cycle();
    checkVal("rst_absent", 32'(bus.rgb), 32'h00F);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NS; i++) begin
          if ($urandom_range(0, 5) == 0)
            setSprite(i, $urandom_range(990, 1023), $urandom_range(0, 40),
                      12'($urandom), 1'($urandom));
          else
            setSprite(i, $urandom_range(0, 100), $urandom_range(0, 130),
                      12'($urandom), ($urandom_range(0, 3) != 0));
        end
      end
      if ($urandom_range(0, 4) == 0)
        setPixel($urandom_range(980, 1023), $urandom_range(0, 50),
                 ($urandom_range(0, 9) != 0), 3'($urandom));
      else
        setPixel($urandom_range(0, 130), $urandom_range(0, 130),
                 ($urandom_range(0, 9) != 0), 3'($urandom));
      bus.frameStart = ($urandom_range(0, 24) == 0);
      reset          = ($urandom_range(0, 299) == 0);
      cycle();
    end
    bus.frameStart = 1'b0;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
